// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and load/store.
// Data wins ties unless fetch has lost STARVE_LIMIT arbitrations in a row.
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic                    if_ready,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_wstrb,
  output logic                    d_ready,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    busy
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);
  localparam int WAIT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic {OWN_FETCH, OWN_DATA} owner_t;

  state_t              r_state;
  state_t              w_nextState;
  owner_t              r_owner;
  logic [CNT_W-1:0]    r_starveCnt;
  logic [WAIT_W-1:0]   r_waitCnt;
  logic                r_we;
  logic [ADDR_WIDTH-1:0] r_memAddr;
  logic [DATA_WIDTH-1:0] r_memWdata;
  logic [STRB_W-1:0]   r_memWstrb;
  logic [DATA_WIDTH-1:0] r_ifRdata;
  logic [DATA_WIDTH-1:0] r_dRdata;
  logic                w_starved;
  logic                w_grantData;
  logic                w_grantFetch;

  always_comb begin
    w_starved    = (r_starveCnt == CNT_W'(STARVE_LIMIT));
    w_grantData  = d_req && !(if_req && w_starved);
    w_grantFetch = if_req && !w_grantData;
  end

  always_comb begin
    w_nextState = r_state;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    if_ready    = 1'b0;
    d_ready     = 1'b0;
    busy        = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        if (w_grantData || w_grantFetch) w_nextState = ISSUE;
      end
      ISSUE: begin
        mem_en      = 1'b1;
        mem_we      = r_we;
        w_nextState = WAIT;
      end
      WAIT: begin
        if (r_waitCnt == '0) w_nextState = RESP;
      end
      RESP: begin
        if_ready    = (r_owner == OWN_FETCH);
        d_ready     = (r_owner == OWN_DATA);
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Request fields are captured at grant time so later requester changes cannot disturb the access.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_owner     <= OWN_FETCH;
      r_starveCnt <= '0;
      r_waitCnt   <= '0;
      r_we        <= 1'b0;
      r_memAddr   <= '0;
      r_memWdata  <= '0;
      r_memWstrb  <= '0;
      r_ifRdata   <= '0;
      r_dRdata    <= '0;
    end else begin
      r_state <= w_nextState;
      case (r_state)
        IDLE: begin
          if (!if_req || w_grantFetch) begin
            r_starveCnt <= '0;
          end else if (w_grantData && !w_starved) begin
            r_starveCnt <= r_starveCnt + 1'b1;
          end
          if (w_grantData) begin
            r_owner    <= OWN_DATA;
            r_we       <= d_we;
            r_memAddr  <= d_addr;
            r_memWdata <= d_wdata;
            r_memWstrb <= d_we ? d_wstrb : '0;
          end else if (w_grantFetch) begin
            r_owner    <= OWN_FETCH;
            r_we       <= 1'b0;
            r_memAddr  <= if_addr;
            r_memWstrb <= '0;
          end
        end
        ISSUE: begin
          r_waitCnt <= WAIT_W'(MEM_LATENCY - 1);
        end
        WAIT: begin
          if (r_waitCnt != '0) begin
            r_waitCnt <= r_waitCnt - 1'b1;
          end else if (!r_we) begin
            if (r_owner == OWN_DATA) r_dRdata <= mem_rdata;
            else                     r_ifRdata <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_addr  = r_memAddr;
  assign mem_wdata = r_memWdata;
  assign mem_wstrb = r_memWstrb;
  assign if_rdata  = r_ifRdata;
  assign d_rdata   = r_dRdata;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

- Shares the single-port unified instruction/data memory between the processor's fetch stage and its load/store stage.
- Accepts one request per requester, selects one per arbitration slot, issues it to memory, waits a fixed latency, then returns read data with a one-cycle ready pulse.
- Data accesses have priority. A starvation counter guarantees forward progress of instruction fetch.

## Interface
- ADDR_WIDTH, 32, address width of both requesters and memory
- DATA_WIDTH, 32, data width; byte-strobe width is DATA_WIDTH/8
- MEM_LATENCY, 1, cycles from the mem_en cycle to the cycle mem_rdata is valid (≥1)
- STARVE_LIMIT, 4, consecutive data-won arbitrations with fetch pending before fetch is forced (≥1)

- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset (0 = reset)
- if_req  in  1  fetch request; held with if_addr stable until if_ready
- if_addr  in  ADDR_WIDTH  fetch address
- if_ready  out  1  one-cycle completion pulse to fetch
- if_rdata  out  DATA_WIDTH  fetched word, valid with if_ready, held after
- d_req  in  1  data request; held with d_* stable until d_ready
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_WIDTH  data address
- d_wdata  in  DATA_WIDTH  store data
- d_wstrb  in  DATA_WIDTH/8  store byte enables
- d_ready  out  1  one-cycle completion pulse to data
- d_rdata  out  DATA_WIDTH  load data, valid with d_ready, held after
- mem_en  out  1  memory access strobe, one cycle per transaction
- mem_we  out  1  memory write enable (valid with mem_en)
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_wstrb  out  DATA_WIDTH/8  memory byte enables
- mem_rdata  in  DATA_WIDTH  memory read data, valid MEM_LATENCY cycles after mem_en
- busy  out  1  1 in every state except IDLE

## Operation
- FSM states: IDLE → ISSUE → WAIT → RESP → IDLE.
- **IDLE:** sample requests and arbitrate.
  - No request: stay in IDLE.
  - Otherwise latch the owner (FETCH or DATA) and that requester's address, data, strobe and we into the mem_* registers, then go to ISSUE.
- **Arbitration:**
  - Data only: grant DATA.
  - Fetch only: grant FETCH.
  - Both: grant DATA unless starve_cnt == STARVE_LIMIT, in which case grant FETCH.
- **starve_cnt** (updated in IDLE only):
  - +1 when DATA is granted while if_req = 1.
  - Cleared when FETCH is granted, or when if_req = 0 in IDLE.
  - Saturates at STARVE_LIMIT.
- **ISSUE:** mem_en = 1 for exactly this cycle, then go to WAIT.
  - Fetch: mem_we = 0 and mem_wstrb = 0.
  - Data: mem_we = d_we; mem_wstrb = d_wstrb for stores, 0 for loads.
- **WAIT:** lasts MEM_LATENCY cycles. In its last cycle, for reads only, capture mem_rdata into the owner's rdata register. Then go to RESP.
- **RESP:** assert the owner's ready for exactly one cycle, then go to IDLE.
  - For stores, d_rdata is unchanged.
  - The non-owner's rdata is always unchanged.
- **Outside ISSUE:**
  - mem_addr, mem_wdata and mem_wstrb hold their last values.
  - mem_en = 0 and mem_we = 0.
- Addresses pass through unchanged; no alignment check.

## Timing
- Reset: while reset = 0 at a rising edge, the FSM goes to IDLE and starve_cnt = 0.
- Reset values: every output is 0 — if_ready, d_ready, if_rdata, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb, busy.
- Reset mid-transaction: the transaction is dropped; no ready pulse is produced and no further mem_en is issued.
- Latency: with the request sampled in IDLE at cycle t:
  - ISSUE at t+1.
  - mem_rdata valid at t+1+MEM_LATENCY.
  - ready at t+2+MEM_LATENCY.
- Transaction period is MEM_LATENCY+3 cycles; maximum throughput is one access per period.
- Handshake:
  - A requester deasserts req in the cycle after its ready, or keeps it high with new fields to request again.
  - req is sampled only in IDLE.
  - Changes to a request while it is not owned are ignored until it is sampled.
- Simultaneous requests resolve per Arbitration.
- The non-granted request stays pending with no side effects.

## Test plan
- **Reset:** hold reset = 0 for 2 cycles with if_req = d_req = 1 → all outputs 0 and no mem_en. Release → mem_en = 1 on the 2nd cycle after release, mem_addr = d_addr.
- **Single fetch (MEM_LATENCY = 1):** if_addr = 0x0000_0010, memory returns 0x0050_0093 → if_ready high exactly 1 cycle, 3 cycles after the IDLE sample; if_rdata = 0x0050_0093; busy low otherwise.
- **Simultaneous requests:** fetch 0x10 and load 0x100 → first mem_en with mem_addr = 0x100 and d_ready first. Next mem_en with mem_addr = 0x10 and if_ready 4 cycles later.
- **Starvation (STARVE_LIMIT = 4):** if_req held, d_req reissued back-to-back → exactly 4 data grants, then 1 fetch grant, then data again; starve_cnt returns to 0.
- **Store:** d_we = 1, addr 0x200, d_wdata 0xDEAD_BEEF, d_wstrb = 0b0011 → on the ISSUE cycle mem_we = 1, mem_wstrb = 0b0011, mem_wdata = 0xDEAD_BEEF; d_ready pulses once; d_rdata unchanged.
- **Reset during WAIT (MEM_LATENCY = 3):** drive reset = 0 in the 2nd WAIT cycle → no ready pulse, outputs zeroed, busy = 0. A pending if_req is granted after reset is released.
